fetch_buffer: RTL and testbench

- Decoupled instruction fetch stage with a parametrised prefetch queue.
- Sits between the instruction port of main memory and decode; replaces the single-cycle fetch PC register.
- Issues sequential fetch addresses and buffers {PC, instruction} pairs in a DEPTH-entry FIFO.
- Decode pops entries with a valid/ready handshake. A redirect from decode or ALU (branch/JAL/JALR) flushes all buffered and in-flight fetches.

---
 rtl/fetch_buffer.sv | 110 +++++++++++
 tb/tb_fetch_buffer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Decoupled instruction fetch stage: issues sequential reads and queues {PC, instruction} pairs for decode.
// Optional macro FETCH_BUFFER_BYPASS_EN forwards returning data straight to decode when the queue is empty.
module fetch_buffer #(
    parameter int          ADDRESS_BITS = 16,
    parameter int          DEPTH        = 4,
    parameter int unsigned RESET_PC     = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [ADDRESS_BITS-1:0]    redirect_PC,
    output logic                       i_req,
    output logic [ADDRESS_BITS-1:0]    i_address,
    input  logic [31:0]                i_read_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDRESS_BITS-1:0]    out_PC,
    output logic [31:0]                out_instruction,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_BITS   = $clog2(DEPTH);
    localparam int COUNT_BITS = $clog2(DEPTH+1);

    logic [ADDRESS_BITS-1:0] fetch_pc;
    logic                    inflight;
    logic [ADDRESS_BITS-1:0] inflight_pc;
    logic [COUNT_BITS-1:0]   count_q;
    logic [PTR_BITS-1:0]     head;
    logic [PTR_BITS-1:0]     tail;
    logic [ADDRESS_BITS-1:0] pc_mem    [DEPTH];
    logic [31:0]             instr_mem [DEPTH];

    logic                    fifo_valid;
    logic                    bypass_valid;
    logic                    pop;
    logic                    fifo_pop;
    logic                    push;
    logic [COUNT_BITS:0]     pending;

    assign fifo_valid = (count_q != '0);

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass_valid = !fifo_valid && inflight && !redirect;
`else
    assign bypass_valid = 1'b0;
`endif

    assign out_valid = fifo_valid || bypass_valid;
    assign pop       = out_valid && out_ready;
    assign fifo_pop  = fifo_valid && out_ready;
    // A bypassed word that decode takes this cycle never lands in storage.
    assign push      = inflight && !redirect && !(bypass_valid && out_ready);

    // Credit check: entries held plus the word in flight, less this cycle's pop, must leave a free slot.
    assign pending   = {1'b0, count_q}
                     + {{COUNT_BITS{1'b0}}, inflight}
                     - {{COUNT_BITS{1'b0}}, pop};
    assign i_req     = reset && !redirect && (pending < (COUNT_BITS+1)'(DEPTH));
    assign i_address = fetch_pc;
    assign count     = count_q;

    always_comb begin
        out_PC          = '0;
        out_instruction = '0;
        if (bypass_valid) begin
            out_PC          = inflight_pc;
            out_instruction = i_read_data;
        end else if (fifo_valid) begin
            out_PC          = pc_mem[head];
            out_instruction = instr_mem[head];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= ADDRESS_BITS'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            count_q     <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_PC;
            inflight <= 1'b0;
            count_q  <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= i_req;
            if (i_req) begin
                fetch_pc    <= fetch_pc + ADDRESS_BITS'(4);
                inflight_pc <= fetch_pc;
            end
            if (push)
                tail <= tail + PTR_BITS'(1);
            if (fifo_pop)
                head <= head + PTR_BITS'(1);
            count_q <= count_q + COUNT_BITS'(push) - COUNT_BITS'(fifo_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[tail]    <= inflight_pc;
            instr_mem[tail] <= i_read_data;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer; a queue-level model tracks outstanding fetches and the expected PC stream.
// Build with FETCH_BUFFER_BYPASS_EN defined to exercise the bypass path.
module tb_fetch_buffer;

    localparam int DEPTH = 4;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_PC;
    logic        i_req;
    logic [15:0] i_address;
    logic [31:0] i_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_PC;
    logic [31:0] out_instruction;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    logic [31:0] salt;

    // Reference model state
    int          outstanding;
    bit          prev_issue;
    logic [15:0] exp_issue;
    logic [15:0] exp_next;
    int          exp_count;
    bit          exp_valid;
    bit          exp_pop;
    bit          exp_req;
    logic [15:0] exp_addr;
    logic [15:0] exp_pc;
    logic [31:0] exp_instr;

    fetch_buffer #(.ADDRESS_BITS(16), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clock(clock),
        .reset(reset),
        .redirect(redirect),
        .redirect_PC(redirect_PC),
        .i_req(i_req),
        .i_address(i_address),
        .i_read_data(i_read_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_PC(out_PC),
        .out_instruction(out_instruction),
        .count(count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a, ~a} ^ salt;
    endfunction

    // Memory: one-cycle read latency, junk when no request was made.
    always @(posedge clock)
        i_read_data <= i_req ? mem_word(i_address) : $urandom;

    task automatic model_reset();
        outstanding = 0;
        prev_issue  = 1'b0;
        exp_issue   = 16'h0000;
        exp_next    = 16'h0000;
    endtask

    task automatic drive(input logic rdy, input logic rd, input logic [15:0] rpc);
        out_ready   = rdy;
        redirect    = rd;
        redirect_PC = rpc;
        #1;
        exp_count = outstanding - int'(prev_issue);
        exp_valid = (exp_count != 0) || (BYPASS && prev_issue && exp_count == 0 && !rd);
        exp_pop   = exp_valid && rdy;
        exp_req   = !rd && (outstanding - int'(exp_pop) < DEPTH);
        exp_addr  = exp_issue;
        exp_pc    = exp_next;
        exp_instr = mem_word(exp_next);
    endtask

    task automatic advance();
        if (redirect) begin
            outstanding = 0;
            prev_issue  = 1'b0;
            exp_issue   = redirect_PC;
            exp_next    = redirect_PC;
        end else begin
            outstanding = outstanding + int'(exp_req) - int'(exp_pop);
            if (exp_req) exp_issue = exp_issue + 16'd4;
            if (exp_pop) exp_next  = exp_next + 16'd4;
            prev_issue = exp_req;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        redirect = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #1;
        checks++; if (i_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_i_req: got %b expected 0", i_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
        checks++; if (out_PC !== 16'h0) begin errors++; $display("[TB] FAIL reset_out_PC: got %h expected 0000", out_PC); end
        checks++; if (out_instruction !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_instr: got %h expected 0", out_instruction); end
        checks++; if (i_address !== 16'h0) begin errors++; $display("[TB] FAIL reset_i_address: got %h expected 0000", i_address); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_stream();
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 1'b0, 16'h0);
            checks++; if (i_req !== exp_req) begin errors++; $display("[TB] FAIL stream_i_req c%0d: got %b expected %b", c, i_req, exp_req); end
            checks++; if (i_address !== exp_addr) begin errors++; $display("[TB] FAIL stream_i_address c%0d: got %h expected %h", c, i_address, exp_addr); end
            checks++; if (out_valid !== exp_valid) begin errors++; $display("[TB] FAIL stream_out_valid c%0d: got %b expected %b", c, out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (out_PC !== exp_pc) begin errors++; $display("[TB] FAIL stream_out_PC c%0d: got %h expected %h", c, out_PC, exp_pc); end
                checks++; if (out_instruction !== exp_instr) begin errors++; $display("[TB] FAIL stream_out_instr c%0d: got %h expected %h", c, out_instruction, exp_instr); end
            end
`ifdef FETCH_BUFFER_BYPASS_EN
            if (c == 1) begin
                checks++; if (out_valid !== 1'b1 || count !== 3'd0) begin errors++; $display("[TB] FAIL bypass_latency: got valid=%b count=%0d expected valid=1 count=0", out_valid, count); end
            end
`else
            if (c == 1) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: got valid=%b expected 0", out_valid); end
            end
            if (c == 2) begin
                checks++; if (out_valid !== 1'b1 || out_PC !== 16'h0) begin errors++; $display("[TB] FAIL latency_first: got valid=%b pc=%h expected valid=1 pc=0000", out_valid, out_PC); end
            end
`endif
            advance();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 1'b0, 16'h0);
            checks++; if (i_req !== exp_req) begin errors++; $display("[TB] FAIL bp_i_req c%0d: got %b expected %b", c, i_req, exp_req); end
            if (exp_req) begin
                checks++; if (i_address !== exp_addr) begin errors++; $display("[TB] FAIL bp_i_address c%0d: got %h expected %h", c, i_address, exp_addr); end
            end
            advance();
        end
        drive(1'b0, 1'b0, 16'h0);
        checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL bp_full_count: got %0d expected 4", count); end
        checks++; if (out_PC !== 16'h0) begin errors++; $display("[TB] FAIL bp_head_pc: got %h expected 0000", out_PC); end
        checks++; if (i_req !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold: got %b expected 0", i_req); end
        checks++; if (i_address !== 16'd16) begin errors++; $display("[TB] FAIL bp_next_addr: got %h expected 0010", i_address); end
        advance();
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 1'b0, 16'h0);
            checks++; if (i_req !== exp_req) begin errors++; $display("[TB] FAIL drain_i_req c%0d: got %b expected %b", c, i_req, exp_req); end
            if (exp_valid) begin
                checks++; if (out_PC !== exp_pc) begin errors++; $display("[TB] FAIL drain_out_PC c%0d: got %h expected %h", c, out_PC, exp_pc); end
                checks++; if (out_instruction !== exp_instr) begin errors++; $display("[TB] FAIL drain_out_instr c%0d: got %h expected %h", c, out_instruction, exp_instr); end
            end
            advance();
        end
    endtask

    task automatic test_redirect();
        bit first_seen;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 1'b0, 16'h0);
            advance();
        end
        drive(1'b0, 1'b1, 16'h0100);
        checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL redir_pre_count: got %0d expected 3", count); end
        checks++; if (i_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_no_issue: got %b expected 0", i_req); end
        advance();
        drive(1'b1, 1'b0, 16'h0);
        checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL redir_count: got %0d expected 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_valid: got %b expected 0", out_valid); end
        checks++; if (i_req !== 1'b1 || i_address !== 16'h0100) begin errors++; $display("[TB] FAIL redir_target: got req=%b addr=%h expected req=1 addr=0100", i_req, i_address); end
        first_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            advance();
            drive(1'b1, 1'b0, 16'h0);
            checks++; if (out_valid !== exp_valid) begin errors++; $display("[TB] FAIL redir_out_valid c%0d: got %b expected %b", c, out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (out_PC !== exp_pc) begin errors++; $display("[TB] FAIL redir_out_PC c%0d: got %h expected %h", c, out_PC, exp_pc); end
                if (!first_seen) begin
                    first_seen = 1'b1;
                    checks++; if (out_PC !== 16'h0100) begin errors++; $display("[TB] FAIL redir_first_pc: got %h expected 0100", out_PC); end
                end
            end
        end
        advance();
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 16'hFFFC);
        advance();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0, 16'h0);
            checks++; if (i_address !== exp_addr) begin errors++; $display("[TB] FAIL wrap_i_address c%0d: got %h expected %h", c, i_address, exp_addr); end
            if (c == 1) begin
                checks++; if (i_address !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_rollover: got %h expected 0000", i_address); end
            end
            if (exp_valid) begin
                checks++; if (out_PC !== exp_pc) begin errors++; $display("[TB] FAIL wrap_out_PC c%0d: got %h expected %h", c, out_PC, exp_pc); end
            end
            advance();
        end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 1'b0, 16'h0);
            advance();
        end
        drive(1'b0, 1'b0, 16'h0);
        checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL mid_pre_count: got %0d expected 2", count); end
        reset = 1'b0;
        #1;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_async_clear: got count=%0d valid=%b expected 0/0", count, out_valid); end
        checks++; if (out_PC !== 16'h0 || out_instruction !== 32'h0) begin errors++; $display("[TB] FAIL mid_async_data: got pc=%h instr=%h expected 0/0", out_PC, out_instruction); end
        checks++; if (i_req !== 1'b0 || i_address !== 16'h0) begin errors++; $display("[TB] FAIL mid_async_fetch: got req=%b addr=%h expected 0/0000", i_req, i_address); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 1'b0, 16'h0);
            checks++; if (i_req !== exp_req || i_address !== exp_addr) begin errors++; $display("[TB] FAIL mid_restart c%0d: got req=%b addr=%h expected req=%b addr=%h", c, i_req, i_address, exp_req, exp_addr); end
            if (exp_valid) begin
                checks++; if (out_PC !== exp_pc) begin errors++; $display("[TB] FAIL mid_out_PC c%0d: got %h expected %h", c, out_PC, exp_pc); end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic        rdy;
        logic        rd;
        logic [15:0] rpc;
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = 16'($urandom) & 16'hFFFC;
            drive(rdy, rd, rpc);
            checks++; if (i_req !== exp_req) begin errors++; $display("[TB] FAIL rand_i_req c%0d: got %b expected %b", c, i_req, exp_req); end
            if (exp_req) begin
                checks++; if (i_address !== exp_addr) begin errors++; $display("[TB] FAIL rand_i_address c%0d: got %h expected %h", c, i_address, exp_addr); end
            end
            checks++; if (count !== 3'(exp_count)) begin errors++; $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", c, count, exp_count); end
            checks++; if (out_valid !== exp_valid) begin errors++; $display("[TB] FAIL rand_out_valid c%0d: got %b expected %b", c, out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (out_PC !== exp_pc) begin errors++; $display("[TB] FAIL rand_out_PC c%0d: got %h expected %h", c, out_PC, exp_pc); end
                checks++; if (out_instruction !== exp_instr) begin errors++; $display("[TB] FAIL rand_out_instr c%0d: got %h expected %h", c, out_instruction, exp_instr); end
            end
            advance();
        end
    endtask

    initial begin
        salt        = $urandom;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_PC = 16'h0;
        out_ready   = 1'b0;
        model_reset();
        @(posedge clock);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
